// File: rtl/noc_output_arbiter_pkg.sv
// Shared NoC definitions for the 5-port router: port and direction encodings,
// flit preamble, flow-control selection, arbiter state and corner-router port
// masks. Direction bit order: [0]=North [1]=South [2]=West [3]=East [4]=Local.
package noc_output_arbiter_pkg;

  localparam int unsigned NumPorts       = 5;
  localparam int unsigned PortQueueDepth = 5;
  localparam int unsigned CreditsWidth   = $clog2(PortQueueDepth + 1);

  typedef enum logic [2:0] {
    kNorthPort = 3'd0,
    kSouthPort = 3'd1,
    kWestPort  = 3'd2,
    kEastPort  = 3'd3,
    kLocalPort = 3'd4
  } noc_port_t;

  typedef logic [NumPorts-1:0] direction_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic {
    kFlowControlCreditBased = 1'b0,
    kFlowControlAckNack     = 1'b1
  } noc_flow_control_t;

  typedef enum logic {
    kArbIdle   = 1'b0,
    kArbLocked = 1'b1
  } arb_state_t;

  localparam direction_t AllPorts               = 5'b11111;
  // Corner routers have no neighbour on two sides.
  localparam direction_t TopLeftRouterPorts     = 5'b11010;
  localparam direction_t TopRightRouterPorts    = 5'b10110;
  localparam direction_t BottomLeftRouterPorts  = 5'b11001;
  localparam direction_t BottomRightRouterPorts = 5'b10101;

  function automatic direction_t get_onehot_port(input noc_port_t port);
    return direction_t'(1) << port;
  endfunction

  // Encodes a one-hot direction; an empty vector maps to North.
  function automatic noc_port_t get_direction(input direction_t dir);
    noc_port_t port;
    case (dir)
      5'b00010: port = kSouthPort;
      5'b00100: port = kWestPort;
      5'b01000: port = kEastPort;
      5'b10000: port = kLocalPort;
      default:  port = kNorthPort;
    endcase
    return port;
  endfunction

  function automatic noc_port_t int2noc_port(input int unsigned idx);
    noc_port_t port;
    case (idx)
      1:       port = kSouthPort;
      2:       port = kWestPort;
      3:       port = kEastPort;
      4:       port = kLocalPort;
      default: port = kNorthPort;
    endcase
    return port;
  endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_picker.sv
// noc_rr_picker: combinational 5-way round-robin pick.
//   req_i  : request vector (direction_t order)
//   last_i : port granted last; the scan starts one past it, Local wraps to North
//   gnt_o  : one-hot winner, zero when nothing requests
module noc_rr_picker
  import noc_output_arbiter_pkg::*;
(
  input  direction_t req_i,
  input  noc_port_t  last_i,
  output direction_t gnt_o
);

  always_comb begin
    gnt_o = '0;
    for (int unsigned off = 1; off <= NumPorts; off++) begin
      automatic logic [2:0] idx = 3'((32'(last_i) + off) % NumPorts);
      if (gnt_o == '0 && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: wormhole switch allocator for one router output port.
// Picks one input by round robin on head flits, holds it until the tail flit,
// and forwards only when downstream can accept (credits or ready).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_i        per-input request towards this output
//   preamble_i   head/tail of each input's front flit
//   credit_i     downstream freed a slot (credit mode)
//   ready_i      downstream accepts this cycle (ack/nack mode)
//   gnt_o        one-hot grant (combinational)
//   sel_o        crossbar select for gnt_o
//   fwd_o        flit transferred this cycle
//   locked_o     packet in progress
//   credits_o    current credit count
//   stall_cnt_o  granted-but-blocked cycle count, only with NOC_ARB_STALL_CNT_EN
module noc_output_arbiter
  import noc_output_arbiter_pkg::*;
#(
  parameter noc_port_t         OutPort     = kLocalPort,
  parameter direction_t        PortsEn     = AllPorts,
  parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
  parameter int unsigned       Depth       = PortQueueDepth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  direction_t                      req_i,
  input  preamble_t [NumPorts-1:0]        preamble_i,
  input  logic                            credit_i,
  input  logic                            ready_i,
  output direction_t                      gnt_o,
  output noc_port_t                       sel_o,
  output logic                            fwd_o,
  output logic                            locked_o,
  output logic [CreditsWidth-1:0]         credits_o
`ifdef NOC_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cnt_o
`endif
);

  localparam logic [CreditsWidth-1:0] DepthCredits = CreditsWidth'(Depth);

  arb_state_t state, state_next;
  noc_port_t  owner, owner_next;
  noc_port_t  rr_last, rr_last_next;
  noc_port_t  gnt_port;

  logic [CreditsWidth-1:0] credits;
  logic       can_send;
  direction_t eligible;
  direction_t heads;
  direction_t rr_winner;

  assign eligible = req_i & PortsEn & ~get_onehot_port(OutPort);

  always_comb begin
    heads = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      heads[k] = preamble_i[k].head;
    end
  end

  noc_rr_picker u_picker (
    .req_i  (eligible & heads),
    .last_i (rr_last),
    .gnt_o  (rr_winner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= kArbIdle;
      owner   <= kNorthPort;
      rr_last <= kLocalPort;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      rr_last <= rr_last_next;
    end
  end

  // Output logic: the grant is shown even without can_send so the crossbar
  // select can settle ahead of the transfer.
  always_comb begin
    gnt_o = '0;
    if (!rst) begin
      if (state == kArbIdle) begin
        gnt_o = rr_winner;
      end else begin
        gnt_o = eligible & get_onehot_port(owner);
      end
    end
    fwd_o    = (|gnt_o) & can_send;
    locked_o = !rst && (state == kArbLocked);
  end

  assign gnt_port = get_direction(gnt_o);
  assign sel_o    = gnt_port;

  // Next-state logic
  always_comb begin
    state_next   = state;
    owner_next   = owner;
    rr_last_next = rr_last;
    if (fwd_o) begin
      if (state == kArbIdle) begin
        if (preamble_i[gnt_port].tail) begin
          rr_last_next = gnt_port;
        end else begin
          state_next = kArbLocked;
          owner_next = gnt_port;
        end
      end else if (preamble_i[owner].tail) begin
        state_next   = kArbIdle;
        rr_last_next = owner;
      end
    end
  end

  generate
    if (FlowControl == kFlowControlCreditBased) begin : g_credit
      logic unused_ready;
      assign unused_ready = ready_i;

      always_ff @(posedge clk) begin
        if (rst) begin
          credits <= DepthCredits;
        end else if (fwd_o && !credit_i) begin
          credits <= credits - CreditsWidth'(1);
        end else if (!fwd_o && credit_i && credits != DepthCredits) begin
          credits <= credits + CreditsWidth'(1);
        end
      end

      assign can_send = (credits != '0);
    end else begin : g_acknack
      logic unused_credit;
      assign unused_credit = credit_i;
      assign credits       = DepthCredits;
      assign can_send      = ready_i;
    end
  endgenerate

  assign credits_o = credits;

`ifdef NOC_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((|gnt_o) && !can_send && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
